// File: rtl/split_bus_arbiter_pkg.sv
// Shared types and constants for the two-master split-transaction bus arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M1 = 2'd1,
        OWN_M2 = 2'd2
    } state_e;

    // Identity of the most recently granted master, used for round-robin ties.
    typedef enum logic {
        MST_M1 = 1'b0,
        MST_M2 = 1'b1
    } master_e;

    localparam logic [1:0] GNT_IDLE = 2'b00;
    localparam logic [1:0] GNT_M1   = 2'b11;
    localparam logic [1:0] GNT_M2   = 2'b10;

endpackage

// File: rtl/split_bus_arbiter_if.sv
// Bus-side handshake signals of the arbiter: requests, split control, grant.
interface split_bus_arbiter_if;

    logic       breq1;
    logic       breq2;
    logic       bbusy;
    logic       split;
    logic       split_done1;
    logic       split_done2;
    logic [1:0] bgrant;
    logic       msplit1;
    logic       msplit2;

    // Arbiter side: consumes requests and split events, drives select code.
    modport slave (
        input  breq1, breq2, bbusy, split, split_done1, split_done2,
        output bgrant, msplit1, msplit2
    );

    // System side: drives requests and split events, observes select code.
    modport master (
        output breq1, breq2, bbusy, split, split_done1, split_done2,
        input  bgrant, msplit1, msplit2
    );

endinterface

// File: rtl/split_bus_arbiter_pick.sv
// Combinational winner select between two eligible requesters.
module arb_pick
    import arb_pkg::*;
#(
    parameter int unsigned RR_MODE = 0
) (
    input  logic    elig1,
    input  logic    elig2,
    input  master_e last_served,
    output logic    win1,
    output logic    win2
);

    // Single requester wins outright; ties go to M1 or to the least recently served.
    always_comb begin
        win1 = 1'b0;
        win2 = 1'b0;
        if (elig1 && elig2) begin
            if ((RR_MODE != 0) && (last_served == MST_M1)) begin
                win2 = 1'b1;
            end else begin
                win1 = 1'b1;
            end
        end else begin
            win1 = elig1;
            win2 = elig2;
        end
    end

endmodule

// File: rtl/split_bus_arbiter.sv
// Two-master bus arbiter: ownership FSM, hold-time limit and split parking.
module split_bus_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned RR_MODE  = 0,
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    split_bus_arbiter_if.slave   bus
);

    localparam int unsigned    CW      = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    state_e        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          ms1_q, ms1_d;
    logic          ms2_q, ms2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    master_e       last_q, last_d;

    logic          elig1, elig2;
    logic          win1, win2;
    logic [CW-1:0] cnt_inc;

    // A parked master is not eligible until its split is resolved.
    assign elig1   = bus.breq1 & ~ms1_q;
    assign elig2   = bus.breq2 & ~ms2_q;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    arb_pick #(.RR_MODE(RR_MODE)) u_pick (
        .elig1       (elig1),
        .elig2       (elig2),
        .last_served (last_q),
        .win1        (win1),
        .win2        (win2)
    );

    // Next-state logic: grant from IDLE, then split / release / forced release.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        // split_done clears the flag; a simultaneous split below sets it again.
        ms1_d   = ms1_q & ~bus.split_done1;
        ms2_d   = ms2_q & ~bus.split_done2;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (win1) begin
                    state_d = OWN_M1;
                    gnt_d   = GNT_M1;
                    last_d  = MST_M1;
                end else if (win2) begin
                    state_d = OWN_M2;
                    gnt_d   = GNT_M2;
                    last_d  = MST_M2;
                end
            end
            OWN_M1: begin
                if (bus.split) begin
                    ms1_d   = 1'b1;
                    state_d = IDLE;
                    gnt_d   = GNT_IDLE;
                    cnt_d   = '0;
                end else if ((!bus.breq1 && !bus.bbusy) ||
                             ((cnt_q == CNT_MAX) && elig2 && !bus.bbusy)) begin
                    state_d = IDLE;
                    gnt_d   = GNT_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            OWN_M2: begin
                if (bus.split) begin
                    ms2_d   = 1'b1;
                    state_d = IDLE;
                    gnt_d   = GNT_IDLE;
                    cnt_d   = '0;
                end else if ((!bus.breq2 && !bus.bbusy) ||
                             ((cnt_q == CNT_MAX) && elig1 && !bus.bbusy)) begin
                    state_d = IDLE;
                    gnt_d   = GNT_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = GNT_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, registered outputs and hold counter; reset releases parked masters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            gnt_q   <= GNT_IDLE;
            ms1_q   <= 1'b0;
            ms2_q   <= 1'b0;
            cnt_q   <= '0;
            last_q  <= MST_M2;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ms1_q   <= ms1_d;
            ms2_q   <= ms2_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign bus.bgrant  = gnt_q;
    assign bus.msplit1 = ms1_q;
    assign bus.msplit2 = ms2_q;

endmodule
